// File: rtl/wb_regfile_retire.sv
// rtl/wb_regfile_retire.sv - write-back select, integer register file and retire counter
// x0 reads zero; both read ports see the in-flight write-back in the same cycle.
module wb_regfile_retire #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] mem_read_data_in,
  input  logic [4:0]      rd_addr_in,
  input  logic [XLEN-1:0] pc_plus_4_in,
  input  logic            reg_write_in,
  input  logic [2:0]      wb_sel_in,
  input  logic            valid_in,
  input  logic [XLEN-1:0] mul_div_result_in,
  input  logic [XLEN-1:0] csr_rdata_in,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            instret_inhibit,
  input  logic            instret_wr_en,
  input  logic [63:0]     instret_wr_data,
  output logic [63:0]     instret
);

  logic [XLEN-1:0] regs_q [1:31];
  logic [XLEN-1:0] regs_d [1:31];
  logic [63:0]     instret_q;
  logic [63:0]     instret_d;

  always_comb begin
    wb_data = '0;
    case (wb_sel_in)
      3'b000:  wb_data = alu_result_in;
      3'b001:  wb_data = mem_read_data_in;
      3'b010:  wb_data = pc_plus_4_in;
      3'b011:  wb_data = csr_rdata_in;
      3'b100:  wb_data = mul_div_result_in;
      default: wb_data = '0;
    endcase
  end

  assign wb_we = valid_in & reg_write_in & (rd_addr_in != 5'd0);
  assign wb_rd = rd_addr_in;

  always_comb begin
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (wb_we && (wb_rd == 5'(i))) begin
        regs_d[i] = wb_data;
      end
    end
  end

  // A CSR write wins over a retirement in the same cycle, which is then not counted.
  always_comb begin
    instret_d = instret_q;
    if (instret_wr_en) begin
      instret_d = instret_wr_data;
    end else if (valid_in && !instret_inhibit) begin
      instret_d = instret_q + 64'd1;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (addr == 5'd0) begin
      val = '0;
    end else if (wb_we && (addr == wb_rd)) begin
      val = wb_data;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (addr == 5'(i)) begin
          val = regs_q[i];
        end
      end
    end
    return val;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      instret_q <= 64'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;

endmodule

// File: doc/wb_regfile_retire.md
Name: wb_regfile_retire

Overview:
- Write-Back stage consumer of the MEM/WB pipeline register outputs.
- Selects the write-back value and writes the 32-entry integer register file (x0 hardwired to zero).
- Provides two ID-stage read ports with same-cycle write-through bypass and a forwarding tap for EX.
- Maintains the 64-bit retired-instruction counter (minstret source) with CSR write and inhibit support.

Parameters:
XLEN, `XLEN (32 or 64), data/address width of the register file and all datapaths.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
alu_result_in  in  XLEN  ALU result from MEM/WB
mem_read_data_in  in  XLEN  load data from MEM/WB
rd_addr_in  in  5  destination register
pc_plus_4_in  in  XLEN  link value for JAL/JALR
reg_write_in  in  1  register write request
wb_sel_in  in  3  write-back source select
valid_in  in  1  instruction in WB is valid
mul_div_result_in  in  XLEN  M-extension result
csr_rdata_in  in  XLEN  CSR read data
rs1_addr  in  5  ID read port 1 address
rs2_addr  in  5  ID read port 2 address
rs1_data  out  XLEN  read port 1 data
rs2_data  out  XLEN  read port 2 data
wb_we  out  1  effective write enable (forwarding tap)
wb_rd  out  5  effective destination (forwarding tap)
wb_data  out  XLEN  selected write-back value (forwarding tap)
instret_inhibit  in  1  mcountinhibit.IR; blocks counting
instret_wr_en  in  1  CSR write to the counter
instret_wr_data  in  64  value for CSR write
instret  out  64  retired-instruction count

Behaviour:
- wb_sel decode (combinational):
  - 000 ALU; 001 MEM; 010 PC+4; 011 CSR; 100 MUL/DIV.
  - 101-111 select zero.
- Effective write: wb_we = valid_in & reg_write_in & (rd_addr_in != 0). wb_rd = rd_addr_in, wb_data = decoded value, both regardless of wb_we.
- Register file:
  - 31 x XLEN flops (x1..x31).
  - On posedge clk with wb_we, regs[wb_rd] <= wb_data. No write when wb_we=0.
  - Writes to x0 are discarded with no side effect.
- Read ports (combinational):
  - Address 0 returns 0.
  - If wb_we and the address equals wb_rd, return wb_data (write-through bypass, same cycle).
  - Otherwise return regs[addr].
  - Both ports may hit the bypass simultaneously.
- Retire counter (64 bits independent of XLEN), priority on posedge clk:
  1. instret_wr_en: instret <= instret_wr_data. A retirement in the same cycle is not counted.
  2. Else if valid_in & !instret_inhibit: instret <= instret + 1.
  3. Else hold.
- Counter wrap: 64'hFFFF_FFFF_FFFF_FFFF + 1 -> 0 silently.
- Counting is independent of reg_write_in and rd_addr_in; stores/branches retire too.
- Reset (asserts asynchronously, no clock needed):
  - All x1..x31 -> 0; instret -> 0.
  - Hence rs1_data/rs2_data read 0 unless bypassing.
  - Reset mid-operation abandons any pending write; the first posedge after deassertion behaves normally.
- Latency: write visible via bypass in the same cycle; visible from regs the cycle after.
- No stall/flush inputs; an upstream bubble arrives as valid_in=0.

Test Plan:
- Reset then read all 32 addresses -> every rs1_data/rs2_data = 0, instret = 0.
- rd=5, wb_sel=000, alu=0x1234, reg_write=1, valid=1, rs1_addr=5 same cycle -> rs1_data=0x1234 via bypass; next cycle with reg_write=0 -> still 0x1234 from array; instret=1.
- Cycle through each wb_sel 000..100 into x1..x5 with distinct values (e.g. 0xA1..0xA5); then write with wb_sel=111 into x6 -> x1..x5 hold the matching source values, x6=0; wb_data = 0 during the 111 cycle.
- rd=0, reg_write=1, valid=1, data=0xDEAD -> wb_we=0, rs1_addr=0 reads 0, instret increments. Repeat with valid=0, rd=3 -> x3 unchanged, no increment.
- instret_wr_data=64'hFFFF_FFFF_FFFF_FFFE with wr_en and valid_in both high -> instret=..FE next cycle. Then two valid retirements -> ..FF, then 0. Then inhibit=1 with valid=1 -> stays 0.
- Assert reset_n=0 asynchronously mid-cycle during a write to x7 after x7=0x55 -> x7 and instret immediately 0; after release, the next write proceeds normally.
